// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared state type, blank pattern and hex glyph table for seven_seg_mux
package seven_seg_pkg;
  typedef enum logic [1:0] {DEAD, ON, OFF} mux_state_t;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction
endpackage

// File: rtl/seven_seg_mux.sv
// seven_seg_mux: two-digit multiplexed hex display driver with dead time and 16-level PWM
module seven_seg_mux
  import seven_seg_pkg::*;
#(
  parameter int SLOT_CYCLES = 6000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic [7:0] value_i,
  input  logic       valid_i,
  input  logic [3:0] brightness_i,
  output logic [6:0] seg_o,
  output logic       digit_o,
  output logic       frame_o
);
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int ACT = SLOT_CYCLES - DEAD_CYCLES;
  logic [7:0] r_pending;
  logic [7:0] r_shadow;
  logic [CW-1:0] r_slot_cnt;
  logic [CW-1:0] r_on_len;
  logic r_digit;
  mux_state_t r_state;
  logic w_slot_end;
  logic w_frame_start;
  logic [CW-1:0] w_on_len;
  logic [CW-1:0] w_off_at;
  logic [3:0] w_nibble;
  always_comb begin
    w_slot_end = r_slot_cnt == CW'(SLOT_CYCLES - 1);
    w_frame_start = r_slot_cnt == '0 && !r_digit;
    w_on_len = CW'((32'(brightness_i) + 32'd1) * 32'(ACT) / 32'd16);
    w_off_at = CW'(DEAD_CYCLES - 1) + r_on_len;
    w_nibble = r_digit ? r_shadow[7:4] : r_shadow[3:0];
  end
  // Outputs are registered from the current slot position, so every output lags the counter by one cycle uniformly.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_pending <= '0;
      r_shadow <= '0;
      r_slot_cnt <= '0;
      r_on_len <= '0;
      r_digit <= 1'b0;
      r_state <= DEAD;
      seg_o <= SEG_OFF;
      digit_o <= 1'b0;
      frame_o <= 1'b0;
    end else begin
      if (valid_i) r_pending <= value_i;
      if (w_frame_start) r_shadow <= r_pending;
      if (r_slot_cnt == '0) r_on_len <= w_on_len;
      if (w_slot_end) r_digit <= ~r_digit;
      r_slot_cnt <= w_slot_end ? '0 : r_slot_cnt + 1'b1;
      r_state <= w_slot_end ? DEAD :
                 (r_state == DEAD && r_slot_cnt == CW'(DEAD_CYCLES - 1)) ? ON :
                 (r_state == ON && r_slot_cnt == w_off_at) ? OFF : r_state;
      seg_o <= r_state == ON ? ~hex7(w_nibble) : SEG_OFF;
      digit_o <= r_digit;
      frame_o <= w_frame_start;
    end
  end
endmodule

// File: doc/seven_seg_mux.md
# seven_seg_mux

Two-digit multiplexed seven-segment driver that sits directly downstream of the SoC's 8-bit `display_o` port on the iCEBreaker PMOD. It shows the byte as two hex digits, time-multiplexing one shared segment bus between two common-anode digits. It adds a per-slot dead time against ghosting and a 16-level PWM brightness. New values are applied only at frame boundaries, so a displayed frame is never a mix of old and new nibbles.

## Interface
- `SLOT_CYCLES`, default 6000: clock cycles per digit slot (500 µs at 12 MHz). `SLOT_CYCLES - DEAD_CYCLES` must be a multiple of 16 and ≥ 16.
- `DEAD_CYCLES`, default 16: cycles at the start of each slot during which all segments are forced off. Must be ≥ 1.

- `clk`  in  1: system clock.
- `reset_i`  in  1: asynchronous, active-high reset.
- `value_i`  in  8: byte to display; high nibble goes to the left digit, low nibble to the right digit.
- `valid_i`  in  1: one-cycle load strobe; captures `value_i` into the pending register.
- `brightness_i`  in  4: on-time level. 0 gives 1/16 of the active window, 15 gives the full window.
- `seg_o`  out  7: segments a..g on bits 0..6, active-low.
- `digit_o`  out  1: digit select. 0 = right (low nibble), 1 = left (high nibble).
- `frame_o`  out  1: one-cycle pulse on the first cycle of each frame, at the shadow-register update.

## Operation
- **Registers:** `pending` (8), `shadow` (8), `slot_cnt` (0..SLOT_CYCLES-1), `digit`, `on_len`, `state`.
- **Loading:** `valid_i` writes `pending` in the same cycle. Multiple strobes within one frame: the last one wins.
- **Frame:** right slot followed by left slot. On the first cycle of a frame (`slot_cnt == 0`, `digit == 0`):
  - `shadow <= pending`
  - `frame_o = 1`
- **Slot start:** on every slot start, `on_len <= (brightness_i + 1) * (SLOT_CYCLES - DEAD_CYCLES) / 16`. Brightness changes therefore take effect only at slot granularity.
- **FSM states:** DEAD, ON, OFF. Transitions:
  - DEAD → ON when `slot_cnt == DEAD_CYCLES - 1`.
  - ON → OFF when `slot_cnt == DEAD_CYCLES + on_len - 1`.
  - OFF, or ON at full brightness → DEAD at slot end (`slot_cnt == SLOT_CYCLES - 1`). At the same time `digit` toggles and `slot_cnt` wraps to 0.
  - When `on_len` equals the whole active window, OFF is skipped.
- **Segment output:**
  - In ON: `seg_o = ~hex7(nibble)`, where nibble = `digit ? shadow[7:4] : shadow[3:0]`.
  - In DEAD and OFF: `seg_o = 7'h7F`.
- **Hex glyphs** (a..g, 1 = lit; `seg_o` is the inverse):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- **`digit_o`** changes only on the DEAD entry cycle, while segments are already blank.
- **Reset** (async assert, sync release):
  - All outputs: `seg_o = 7'h7F`, `digit_o = 0`, `frame_o = 0`.
  - Internal state: `pending = shadow = 8'h00`, `slot_cnt = 0`, state DEAD, `on_len = 0`.
  - Reset asserted mid-slot blanks `seg_o` immediately.
  - The first cycle after release is a frame start: `frame_o = 1`, and `shadow` loads `pending` (0x00).
- **Same-cycle strobe at frame start:** `valid_i` coinciding with the frame-start cycle updates `pending` only. `shadow` takes the old `pending`, and the new value appears one frame later.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- Load-to-display latency: between 1 and 2×`SLOT_CYCLES` cycles to the next frame start, plus 1 register stage.
- Frame period: 2×`SLOT_CYCLES`. `frame_o` pulses exactly once per period.
- Lit cycles per slot: exactly `on_len`, starting at slot cycle `DEAD_CYCLES`.
- `seg_o` is blank for ≥ `DEAD_CYCLES` cycles around every `digit_o` edge.

## Structure
- **Package `seven_seg_pkg`:**
  - `mux_state_t` enum (DEAD, ON, OFF).
  - `hex7` function (4 → 7 glyph table).
  - Localparam `SEG_OFF = 7'h7F`.
- No sub-module: prescaler, FSM and decode fit in one module. At board level, `seg_o`/`digit_o` replace the direct P1B pin assignment of `display_o`.

## Test plan
Bench parameters: `SLOT_CYCLES=34`, `DEAD_CYCLES=2` (active window 32).
- **Reset:** reset released, no strobe → `frame_o` pulses on the first cycle. Every ON cycle shows `seg_o = 7'h40` ("0") on both digits. `seg_o = 7'h7F` during reset.
- **Load:** `valid_i` with `value_i = 8'hA5`, brightness 15 → after the next `frame_o`:
  - right slot: 32 cycles of `~6D` = `7'h12`.
  - left slot: 32 cycles of `~77` = `7'h08`.
  - Cycles 0–1 of each slot are blank.
- **Brightness:** `brightness_i = 0` → exactly 2 lit cycles per slot (cycles 2–3). `brightness_i = 7` → 16 lit cycles.
- **Anti-tearing:** strobe 0x12 mid-left-slot, then 0x34 before the frame end → the frame continues with the old value, and the next frame shows "34". "12" is never displayed.
- **Mid-operation reset:** `reset_i` asserted during ON of the left slot → `seg_o = 7'h7F` and `digit_o = 0` in the same cycle (async). After release: `frame_o` pulses and "00" is displayed.
- **Ghosting check:** over 10 frames, assert that every `digit_o` toggle occurs with `seg_o == 7'h7F` and that `frame_o` has period 68.
